// File: rtl/SH7604_PKG.sv
// Shared types and constants for the instruction/data bus arbiter.
// Masters: index 0 = CPU/cache, 1 = DMA ch0, 2 = DMA ch1.
package SH7604_PKG;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_C    = 2'd1;
    localparam logic [1:0] GNT_D0   = 2'd2;
    localparam logic [1:0] GNT_D1   = 2'd3;

    localparam int NUM_M = 3;

    // One master's view of the bus request.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] wdata;
        logic [3:0]  ba;
        logic        we;
        logic        req;
        logic        lock;
    } ibus_req_t;

endpackage

// File: rtl/IBUS_ARB_PRI.sv
// Combinational winner selection for the bus arbiter.
// With IBUS_ARB_RR_EN defined, D0/D1 ties go to the channel not served last.
module IBUS_ARB_PRI
    import SH7604_PKG::*;
(
    input  logic [2:0] REQ,       // {D1, D0, C}
    input  logic       CPU_TURN,
    input  logic       RR_PTR,    // 1: D1 was the last DMA channel granted
    output logic [1:0] GNT
);

`ifdef IBUS_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    always_comb begin
        GNT = GNT_NONE;
        if (CPU_TURN && REQ[0])
            GNT = GNT_C;
        else if (REQ[2] && REQ[1])
            GNT = (RR_EN && RR_PTR) ? GNT_D0 : GNT_D1;
        else if (REQ[2])
            GNT = GNT_D1;
        else if (REQ[1])
            GNT = GNT_D0;
        else if (REQ[0])
            GNT = GNT_C;
    end

endmodule

// File: rtl/ibus_arb.sv
// Three-master bus arbiter (CPU, DMA0, DMA1) onto one slave port, with bus lock
// and CPU cycle-steal after DMA accesses. Optional macro: IBUS_ARB_RR_EN.
module ibus_arb
    import SH7604_PKG::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [31:0] C_A,
    input  logic [31:0] C_DO,
    input  logic [3:0]  C_BA,
    input  logic        C_WE,
    input  logic        C_REQ,
    input  logic        C_LOCK,
    output logic        C_WAIT,
    input  logic [31:0] D0_A,
    input  logic [31:0] D0_DO,
    input  logic [3:0]  D0_BA,
    input  logic        D0_WE,
    input  logic        D0_REQ,
    input  logic        D0_LOCK,
    output logic        D0_WAIT,
    input  logic [31:0] D1_A,
    input  logic [31:0] D1_DO,
    input  logic [3:0]  D1_BA,
    input  logic        D1_WE,
    input  logic        D1_REQ,
    input  logic        D1_LOCK,
    output logic        D1_WAIT,
    output logic [31:0] M_DI,
    output logic [31:0] S_A,
    output logic [31:0] S_DO,
    output logic [3:0]  S_BA,
    output logic        S_WE,
    output logic        S_REQ,
    output logic        S_LOCK,
    input  logic [31:0] S_DI,
    input  logic        S_WAIT,
    output logic [1:0]  GNT
);

    arb_state_t           state, state_n;
    logic [1:0]           gnt, gnt_n, win;
    logic                 cpu_turn, cpu_turn_n, pri_turn;
    logic                 rr_ptr, rr_ptr_n;
    logic                 done, dma_done, arb;
    ibus_req_t [NUM_M-1:0] mreq;
    ibus_req_t            sel;

    assign mreq[0] = '{a: C_A,  wdata: C_DO,  ba: C_BA,  we: C_WE,  req: C_REQ,  lock: C_LOCK};
    assign mreq[1] = '{a: D0_A, wdata: D0_DO, ba: D0_BA, we: D0_WE, req: D0_REQ, lock: D0_LOCK};
    assign mreq[2] = '{a: D1_A, wdata: D1_DO, ba: D1_BA, we: D1_WE, req: D1_REQ, lock: D1_LOCK};

    always_comb begin
        sel = '0;
        case (gnt)
            GNT_C:   sel = mreq[0];
            GNT_D0:  sel = mreq[1];
            GNT_D1:  sel = mreq[2];
            default: sel = '0;
        endcase
    end

    assign S_A    = sel.a;
    assign S_DO   = sel.wdata;
    assign S_BA   = sel.ba;
    assign S_WE   = sel.we;
    assign S_REQ  = sel.req;
    assign S_LOCK = sel.lock;
    assign M_DI   = S_DI;
    assign GNT    = gnt;

    assign C_WAIT  = C_REQ  & ~((gnt == GNT_C)  & ~S_WAIT);
    assign D0_WAIT = D0_REQ & ~((gnt == GNT_D0) & ~S_WAIT);
    assign D1_WAIT = D1_REQ & ~((gnt == GNT_D1) & ~S_WAIT);

    assign done     = S_REQ & ~S_WAIT;
    assign dma_done = done & ((gnt == GNT_D0) | (gnt == GNT_D1));
    // A DMA access finishing this cycle already entitles C to the re-arbitration.
    assign pri_turn = cpu_turn | dma_done;

    IBUS_ARB_PRI u_pri (
        .REQ      ({D1_REQ, D0_REQ, C_REQ}),
        .CPU_TURN (pri_turn),
        .RR_PTR   (rr_ptr),
        .GNT      (win)
    );

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        cpu_turn_n = cpu_turn;
        rr_ptr_n   = rr_ptr;
        arb        = 1'b0;
        case (state)
            ST_IDLE: arb = C_REQ | D0_REQ | D1_REQ;
            ST_OWN: begin
                if (done) begin
                    if (sel.lock) state_n = ST_LOCKED;
                    else          arb     = 1'b1;
                end else if (!sel.req) begin
                    state_n = ST_IDLE;
                    gnt_n   = GNT_NONE;
                end
            end
            ST_LOCKED: arb = done & ~sel.lock;
            default: begin
                state_n = ST_IDLE;
                gnt_n   = GNT_NONE;
            end
        endcase
        if (dma_done) cpu_turn_n = 1'b1;
        if (arb) begin
            gnt_n   = win;
            state_n = (win == GNT_NONE) ? ST_IDLE : ST_OWN;
            if (win == GNT_C)  cpu_turn_n = 1'b0;
            if (win == GNT_D0) rr_ptr_n   = 1'b0;
            if (win == GNT_D1) rr_ptr_n   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            gnt      <= GNT_NONE;
            cpu_turn <= 1'b0;
            rr_ptr   <= 1'b0;
        end else if (CE_R) begin
            state    <= state_n;
            gnt      <= gnt_n;
            cpu_turn <= cpu_turn_n;
            rr_ptr   <= rr_ptr_n;
        end
    end

endmodule

// File: tb/tb_ibus_arb.sv
// Directed bench for ibus_arb: per-cycle vector table plus hand-written
// sequences for lock, slave stall, reset mid-access and D0/D1 alternation.
module tb_ibus_arb;

    logic        CLK = 1'b0;
    logic        RST, CE_R;
    logic [31:0] C_A, C_DO, D0_A, D0_DO, D1_A, D1_DO;
    logic [3:0]  C_BA, D0_BA, D1_BA;
    logic        C_WE, C_REQ, C_LOCK, C_WAIT;
    logic        D0_WE, D0_REQ, D0_LOCK, D0_WAIT;
    logic        D1_WE, D1_REQ, D1_LOCK, D1_WAIT;
    logic [31:0] M_DI, S_A, S_DO, S_DI;
    logic [3:0]  S_BA;
    logic        S_WE, S_REQ, S_LOCK, S_WAIT;
    logic [1:0]  GNT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ibus_arb dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R),
        .C_A(C_A), .C_DO(C_DO), .C_BA(C_BA), .C_WE(C_WE), .C_REQ(C_REQ), .C_LOCK(C_LOCK), .C_WAIT(C_WAIT),
        .D0_A(D0_A), .D0_DO(D0_DO), .D0_BA(D0_BA), .D0_WE(D0_WE), .D0_REQ(D0_REQ), .D0_LOCK(D0_LOCK), .D0_WAIT(D0_WAIT),
        .D1_A(D1_A), .D1_DO(D1_DO), .D1_BA(D1_BA), .D1_WE(D1_WE), .D1_REQ(D1_REQ), .D1_LOCK(D1_LOCK), .D1_WAIT(D1_WAIT),
        .M_DI(M_DI), .S_A(S_A), .S_DO(S_DO), .S_BA(S_BA), .S_WE(S_WE), .S_REQ(S_REQ), .S_LOCK(S_LOCK),
        .S_DI(S_DI), .S_WAIT(S_WAIT), .GNT(GNT)
    );

    typedef struct {
        logic       ce, c, d0, d1, sw;
        logic [1:0] gnt;
        logic       sreq;
        logic [2:0] waits;   // {D1, D0, C}
    } vec_t;

    vec_t tv[14];

    function automatic logic [31:0] addr_of(input logic [1:0] g);
        case (g)
            2'd1:    return 32'h0600_0000;
            2'd2:    return 32'h2000_0010;
            2'd3:    return 32'h3000_0020;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic c, input logic d0, input logic d1);
        C_REQ = c; D0_REQ = d0; D1_REQ = d1;
    endtask

    initial begin
        RST = 1'b1; CE_R = 1'b1; S_WAIT = 1'b0; S_DI = 32'h1234_5678;
        C_A  = 32'h0600_0000; C_DO  = 32'hC0C0_C0C0; C_BA  = 4'hF; C_WE  = 1'b0; C_LOCK  = 1'b0;
        D0_A = 32'h2000_0010; D0_DO = 32'hD0D0_D0D0; D0_BA = 4'h3; D0_WE = 1'b0; D0_LOCK = 1'b0;
        D1_A = 32'h3000_0020; D1_DO = 32'hD1D1_D1D1; D1_BA = 4'hC; D1_WE = 1'b1; D1_LOCK = 1'b0;
        set_req(1'b1, 1'b0, 1'b0);

        //           ce c  d0 d1 sw  gnt  sreq waits
        tv[0]  = '{1, 1, 0, 0, 0, 2'd1, 1, 3'b000};
        tv[1]  = '{1, 1, 0, 0, 0, 2'd1, 1, 3'b000};
        tv[2]  = '{1, 0, 0, 0, 0, 2'd0, 0, 3'b000};
        tv[3]  = '{1, 1, 1, 1, 0, 2'd3, 1, 3'b011};
        tv[4]  = '{1, 1, 1, 1, 1, 2'd3, 1, 3'b111};
        tv[5]  = '{1, 1, 1, 1, 0, 2'd1, 1, 3'b110};
`ifdef IBUS_ARB_RR_EN
        tv[6]  = '{1, 1, 1, 1, 0, 2'd2, 1, 3'b101};
`else
        tv[6]  = '{1, 1, 1, 1, 0, 2'd3, 1, 3'b011};
`endif
        tv[7]  = '{1, 0, 0, 0, 0, 2'd0, 0, 3'b000};
        tv[8]  = '{0, 1, 0, 0, 0, 2'd0, 0, 3'b001};
        tv[9]  = '{0, 1, 0, 0, 0, 2'd0, 0, 3'b001};
        tv[10] = '{1, 1, 0, 0, 0, 2'd1, 1, 3'b000};
        tv[11] = '{0, 1, 0, 0, 0, 2'd1, 1, 3'b000};
        tv[12] = '{0, 0, 0, 0, 0, 2'd1, 0, 3'b000};
        tv[13] = '{1, 0, 0, 0, 0, 2'd0, 0, 3'b000};

        // Reset state, with C already requesting.
        cyc(); cyc();
        chk("rst_gnt", {30'd0, GNT}, 32'd0);
        chk("rst_sreq", {31'd0, S_REQ}, 32'd0);
        chk("rst_sa", S_A, 32'd0);
        chk("rst_waits", {29'd0, D1_WAIT, D0_WAIT, C_WAIT}, 32'd1);
        chk("m_di", M_DI, 32'h1234_5678);
        RST = 1'b0;

        for (int i = 0; i < 14; i++) begin
            CE_R = tv[i].ce; S_WAIT = tv[i].sw;
            set_req(tv[i].c, tv[i].d0, tv[i].d1);
            cyc();
            chk($sformatf("v%0d_gnt", i), {30'd0, GNT}, {30'd0, tv[i].gnt});
            chk($sformatf("v%0d_sreq", i), {31'd0, S_REQ}, {31'd0, tv[i].sreq});
            chk($sformatf("v%0d_waits", i), {29'd0, D1_WAIT, D0_WAIT, C_WAIT}, {29'd0, tv[i].waits});
            chk($sformatf("v%0d_sa", i), S_A, addr_of(tv[i].gnt));
            chk($sformatf("v%0d_swe", i), {31'd0, S_WE}, {31'd0, tv[i].gnt == 2'd3});
        end

        // Lock: D0 holds the bus for 4 locked accesses while D1 waits.
        CE_R = 1'b1; S_WAIT = 1'b0; D0_LOCK = 1'b1;
        set_req(1'b0, 1'b1, 1'b0);
        cyc();
        chk("lk_grant", {30'd0, GNT}, 32'd2);
        chk("lk_slock", {31'd0, S_LOCK}, 32'd1);
        chk("lk_sba", {28'd0, S_BA}, 32'h3);
        D1_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("lk%0d_gnt", i), {30'd0, GNT}, 32'd2);
            chk($sformatf("lk%0d_d1w", i), {31'd0, D1_WAIT}, 32'd1);
        end
        D0_REQ = 1'b0;
        cyc();
        chk("lk_noreq_hold", {30'd0, GNT}, 32'd2);
        D0_REQ = 1'b1; D0_LOCK = 1'b0;
        cyc();
        chk("lk_release", {30'd0, GNT}, 32'd3);

        // Slave stall during D1 access: five stalled cycles, completes on the sixth.
        D0_REQ = 1'b0; S_WAIT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("st%0d_gnt", i), {30'd0, GNT}, 32'd3);
            chk($sformatf("st%0d_d1w", i), {31'd0, D1_WAIT}, 32'd1);
        end
        S_WAIT = 1'b0; C_REQ = 1'b1;
        #1;
        chk("st_d1w_release", {31'd0, D1_WAIT}, 32'd0);
        chk("st_sdo", S_DO, 32'hD1D1_D1D1);
        cyc();
        chk("st_cpu_steal", {30'd0, GNT}, 32'd1);

        // Reset mid-access while D0 owns the bus and cpu_turn is set.
        set_req(1'b0, 1'b0, 1'b0);
        cyc();
        chk("rm_idle", {30'd0, GNT}, 32'd0);
        D0_REQ = 1'b1;
        cyc();
        cyc();   // D0 completes and is re-granted: cpu_turn now set
        chk("rm_d0", {30'd0, GNT}, 32'd2);
        S_WAIT = 1'b1; RST = 1'b1; CE_R = 1'b0;
        cyc();
        chk("rm_gnt", {30'd0, GNT}, 32'd0);
        chk("rm_sreq", {31'd0, S_REQ}, 32'd0);
        chk("rm_d0w", {31'd0, D0_WAIT}, 32'd1);
        chk("rm_cw", {31'd0, C_WAIT}, 32'd0);
        RST = 1'b0; CE_R = 1'b1; S_WAIT = 1'b0;
        set_req(1'b1, 1'b1, 1'b1);
        cyc();
        chk("rm_turn_clr", {30'd0, GNT}, 32'd3);

        // D0/D1 alternation from a fresh reset with C idle.
        RST = 1'b1;
        set_req(1'b0, 1'b0, 1'b0);
        cyc();
        RST = 1'b0;
        set_req(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
`ifdef IBUS_ARB_RR_EN
            chk($sformatf("rr%0d_gnt", i), {30'd0, GNT}, (i % 2 == 0) ? 32'd3 : 32'd2);
`else
            chk($sformatf("rr%0d_gnt", i), {30'd0, GNT}, 32'd3);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
